store_align_unit: RTL and testbench
===================================

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 The block SHALL have parameter ALLOW_MISALIGNED, default 1: 1 = split a misaligned store into two bus beats; 0 = reject a misaligned store with an error.
REQ-002 The block SHALL have one clock, clk, input, 1 bit; all state changes on its rising edge.
REQ-003 The block SHALL have reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have req_valid, input, 1 bit: a store request is present.
REQ-005 The block SHALL have req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have req_addr, input, 32 bits: byte address.
REQ-007 The block SHALL have req_data, input, 32 bits: store data, right-justified.
REQ-008 The block SHALL have store, input, 2 bits: 2'b01 sb, 2'b10 sh, 2'b00/2'b11 sw.
REQ-009 The block SHALL have mem_valid, output, 1 bit: a write beat is presented.
REQ-010 The block SHALL have mem_ready, input, 1 bit: memory accepts the beat.
REQ-011 The block SHALL have mem_addr, output, 32 bits: word-aligned address, [1:0] = 0.
REQ-012 The block SHALL have mem_wdata, output, 32 bits: little-endian lane-placed data.
REQ-013 The block SHALL have mem_wstrb, output, 4 bits: byte enables, bit i = byte lane i.
REQ-014 The block SHALL have done, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have err, output, 1 bit: one-cycle pulse flagging a rejected misaligned request.

Function
REQ-016 The FSM SHALL have states IDLE, BEAT1, BEAT2; req_ready SHALL equal 1 only in IDLE.
REQ-017 A request SHALL be accepted when req_valid and req_ready are both 1, and addr, data and store SHALL be registered on acceptance.
REQ-018 Definitions: off = req_addr[1:0]; mask = 0001 for sb, 0011 for sh, 1111 for sw; wide = {4'b0,mask} << off (8 bits); split = (wide[7:4] != 0).
REQ-019 In BEAT1: mem_addr = {addr[31:2],2'b00}; mem_wstrb = wide[3:0]; mem_wdata = (data << 8*off), with bytes not enabled forced to 0.
REQ-020 In BEAT2: mem_addr = BEAT1 address + 4, wrapping modulo 2^32; mem_wstrb = wide[7:4]; mem_wdata = (data >> 8*(4-off)), with bytes not enabled forced to 0.
REQ-021 On acceptance, the FSM SHALL go IDLE -> BEAT1 on the next edge; mem_valid SHALL be 1 in BEAT1 and BEAT2.
REQ-022 Once mem_valid is 1, mem_addr, mem_wdata and mem_wstrb SHALL be held stable until mem_ready is sampled 1.
REQ-023 A beat is accepted in a cycle where mem_valid and mem_ready are both 1. On BEAT1 acceptance the FSM SHALL go to BEAT2 if split, else to IDLE; on BEAT2 acceptance it SHALL go to IDLE.
REQ-024 done SHALL be 1 in exactly the cycle after the final beat's acceptance, which is the first IDLE cycle; a new request SHALL be acceptable in that same cycle.
REQ-025 Minimum latency from acceptance to done SHALL be 2 cycles for an aligned store and 3 cycles for a split store, each added cycle of mem_ready=0 adding 1.
REQ-026 If ALLOW_MISALIGNED=0 and split, the block SHALL accept the request, issue no beat, remain in IDLE, and pulse err (not done) in the next cycle.
REQ-027 Aligned sb at any offset and sh at offset 0–2 SHALL never split; an sw at offset 0 SHALL never split.
REQ-028 req_valid while not in IDLE SHALL be ignored with no state effect; the requester holds its request.
REQ-029 mem_wdata and mem_wstrb SHALL be 0 whenever mem_valid is 0.

Reset
REQ-030 While reset is 1 at a rising edge: FSM -> IDLE; mem_valid, mem_wstrb, mem_wdata, mem_addr, done, err -> 0; req_ready SHALL be 1 from the first cycle after reset.
REQ-031 Reset asserted during BEAT1 or BEAT2 SHALL abort the store: a pending beat is dropped, no done, and no BEAT2 is issued afterward.

Verification
REQ-032 sb, addr 0x00001001, data 0xAABBCCDD, mem_ready=1 -> one beat: addr 0x00001000, wdata 0x0000DD00, wstrb 0010; done 2 cycles after acceptance.
REQ-033 sh, addr 0x00002003, data 0x00001234 -> beat1: 0x00002000, 0x34000000, 1000; beat2: 0x00002004, 0x00000012, 0001; single done.
REQ-034 sw, addr 0x00003002, data 0x11223344, mem_ready low 3 cycles in BEAT1 -> beat1 0x00003000, 0x33440000, 1100, held stable; then beat2 0x00003004, 0x00001122, 0011.
REQ-035 sw at 0xFFFFFFFE -> beat2 addr wraps to 0x00000000 with wstrb 0011.
REQ-036 ALLOW_MISALIGNED=0, sw at 0x00000001 -> no mem_valid; err pulses once; done stays 0.
REQ-037 Reset during stalled BEAT1 of a split sh -> mem_valid 0 next cycle, no BEAT2, no done, req_ready 1.

Source files
------------

// File: rtl/store_align_unit.sv
// Store alignment unit: places sb/sh/sw store data onto a word-wide write bus,
// splitting a store that crosses a word boundary into two beats (or rejecting it).
module store_align_unit #(
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  store,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT1,
        BEAT2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  store_q, store_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [7:0]  wide;
    logic [63:0] shifted;
    logic [31:0] beat1_addr;

    function automatic logic [7:0] lane_span(input logic [1:0] off, input logic [1:0] st);
        logic [3:0] mask;
        case (st)
            2'b01:   mask = 4'b0001;
            2'b10:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return {4'b0000, mask} << off;
    endfunction

    function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] st);
        logic [7:0] span;
        span = lane_span(off, st);
        return span[7:4] != 4'b0000;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    assign wide       = lane_span(addr_q[1:0], store_q);
    // Upper word of the 64-bit shift equals data >> 8*(4-off), i.e. the second beat.
    assign shifted    = {32'h0000_0000, data_q} << {addr_q[1:0], 3'b000};
    assign beat1_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        store_d   = store_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        req_ready = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    data_d  = req_data;
                    store_d = store;
                    if ((ALLOW_MISALIGNED == 0) && crosses_word(req_addr[1:0], store)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = BEAT1;
                    end
                end
            end
            BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = beat1_addr;
                mem_wstrb = wide[3:0];
                mem_wdata = shifted[31:0] & byte_mask(wide[3:0]);
                if (mem_ready) begin
                    if (wide[7:4] != 4'b0000) begin
                        state_d = BEAT2;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            BEAT2: begin
                mem_valid = 1'b1;
                mem_addr  = beat1_addr + 32'd4;
                mem_wstrb = wide[7:4];
                mem_wdata = shifted[63:32] & byte_mask(wide[7:4]);
                if (mem_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            store_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            store_q <= store_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: vector table driven through a beat scoreboard,
// plus reset-abort and reject-mode sequences.
module tb_store_align_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [1:0]  store;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done, err;

    logic        r0_valid, r0_ready;
    logic [31:0] r0_addr, r0_data;
    logic [1:0]  r0_store;
    logic        m0_valid, m0_ready;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        done0, err0;

    store_align_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .store(store),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .done(done), .err(err)
    );

    store_align_unit #(.ALLOW_MISALIGNED(0)) dut_rej (
        .clk(clk), .reset(reset),
        .req_valid(r0_valid), .req_ready(r0_ready),
        .req_addr(r0_addr), .req_data(r0_data), .store(r0_store),
        .mem_valid(m0_valid), .mem_ready(m0_ready),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_wstrb(m0_wstrb),
        .done(done0), .err(err0)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          stall;
    } beat_t;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] data;
        int          nb;
        logic [31:0] a1; logic [31:0] d1; logic [3:0] s1; int st1;
        logic [31:0] a2; logic [31:0] d2; logic [3:0] s2; int st2;
        bit          hold;
    } vec_t;

    beat_t sbq[$];
    int    stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!reset && mem_valid && mem_ready && sbq.size() > 0) begin
            void'(sbq.pop_front());
            stall_cnt = 0;
        end
    end

    // Compares the presented beat every cycle, so stalled beats are also checked for stability.
    always @(negedge clk) begin
        if (reset) begin
            mem_ready = 1'b0;
        end else if (mem_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected beat", 32'(mem_valid), 32'd0);
                mem_ready = 1'b1;
            end else begin
                chk("beat addr", mem_addr, sbq[0].addr);
                chk("beat wdata", mem_wdata, sbq[0].wdata);
                chk("beat wstrb", 32'(mem_wstrb), 32'(sbq[0].strb));
                if (stall_cnt < sbq[0].stall) begin
                    mem_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    mem_ready = 1'b1;
                end
            end
        end else begin
            chk("idle wdata", mem_wdata, 32'd0);
            chk("idle wstrb", 32'(mem_wstrb), 32'd0);
            mem_ready = 1'b0;
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic run_vec(input int idx, input vec_t v);
        int  acc, exp_done, n;
        bit  got;
        beat_t b;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_data  = v.data;
        store     = v.st;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
        acc = cyc;
        b.addr = v.a1; b.wdata = v.d1; b.strb = v.s1; b.stall = v.st1;
        sbq.push_back(b);
        if (v.nb == 2) begin
            b.addr = v.a2; b.wdata = v.d2; b.strb = v.s2; b.stall = v.st2;
            sbq.push_back(b);
        end
        exp_done = acc + 1 + v.nb + v.st1 + ((v.nb == 2) ? v.st2 : 0);
        @(posedge clk);
        #1;
        if (v.hold) begin
            req_addr = 32'hDEAD_0001;
            req_data = 32'h0;
            store    = 2'b00;
        end else begin
            req_valid = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                req_valid = 1'b0;
                chk($sformatf("v%0d done cycle", idx), 32'(cyc), 32'(exp_done));
                chk($sformatf("v%0d err", idx), 32'(err), 32'd0);
                chk($sformatf("v%0d ready at done", idx), 32'(req_ready), 32'd1);
                chk($sformatf("v%0d beats left", idx), 32'(sbq.size()), 32'd0);
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d done timeout: got no done expected done at cycle %0d", idx, exp_done);
            req_valid = 1'b0;
        end
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{2'b01, 32'h0000_1001, 32'hAABB_CCDD, 1, 32'h0000_1000, 32'h0000_DD00, 4'b0010, 0, 32'h0, 32'h0, 4'b0000, 0, 1'b0};
        vecs[1]  = '{2'b10, 32'h0000_2003, 32'h0000_1234, 2, 32'h0000_2000, 32'h3400_0000, 4'b1000, 0, 32'h0000_2004, 32'h0000_0012, 4'b0001, 0, 1'b0};
        vecs[2]  = '{2'b00, 32'h0000_3002, 32'h1122_3344, 2, 32'h0000_3000, 32'h3344_0000, 4'b1100, 3, 32'h0000_3004, 32'h0000_1122, 4'b0011, 0, 1'b1};
        vecs[3]  = '{2'b00, 32'hFFFF_FFFE, 32'hCAFE_BABE, 2, 32'hFFFF_FFFC, 32'hBABE_0000, 4'b1100, 0, 32'h0000_0000, 32'h0000_CAFE, 4'b0011, 2, 1'b0};
        vecs[4]  = '{2'b00, 32'h0000_4000, 32'hDEAD_BEEF, 1, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 0, 32'h0, 32'h0, 4'b0000, 0, 1'b0};
        vecs[5]  = '{2'b01, 32'h0000_5003, 32'h1234_56A5, 1, 32'h0000_5000, 32'hA500_0000, 4'b1000, 1, 32'h0, 32'h0, 4'b0000, 0, 1'b0};
        vecs[6]  = '{2'b10, 32'h0000_6002, 32'hFFFF_8765, 1, 32'h0000_6000, 32'h8765_0000, 4'b1100, 0, 32'h0, 32'h0, 4'b0000, 0, 1'b0};
        vecs[7]  = '{2'b10, 32'h0000_7000, 32'hAAAA_5AA5, 1, 32'h0000_7000, 32'h0000_5AA5, 4'b0011, 0, 32'h0, 32'h0, 4'b0000, 0, 1'b0};
        vecs[8]  = '{2'b11, 32'h0000_8001, 32'h0102_0304, 2, 32'h0000_8000, 32'h0203_0400, 4'b1110, 0, 32'h0000_8004, 32'h0000_0001, 4'b0001, 1, 1'b0};
        vecs[9]  = '{2'b00, 32'h0000_9003, 32'hA1B2_C3D4, 2, 32'h0000_9000, 32'hD400_0000, 4'b1000, 0, 32'h0000_9004, 32'h00A1_B2C3, 4'b0111, 0, 1'b0};
        vecs[10] = '{2'b10, 32'h0000_A001, 32'h0000_BEEF, 1, 32'h0000_A000, 32'h00BE_EF00, 4'b0110, 0, 32'h0, 32'h0, 4'b0000, 0, 1'b0};
        vecs[11] = '{2'b01, 32'h0000_B000, 32'hFFFF_FF7F, 1, 32'h0000_B000, 32'h0000_007F, 4'b0001, 0, 32'h0, 32'h0, 4'b0000, 0, 1'b0};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        store     = 2'b00;
        r0_valid  = 1'b0;
        r0_addr   = '0;
        r0_data   = '0;
        r0_store  = 2'b00;
        m0_ready  = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset mem_valid", 32'(mem_valid), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready after reset", 32'(req_ready), 32'd1);

        // Back-to-back: each vector is driven in the done cycle of the previous one.
        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset during a stalled first beat of a split sh.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_2003;
        req_data  = 32'h0000_5678;
        store     = 2'b10;
        chk("abort req_ready", 32'(req_ready), 32'd1);
        sbq.push_back('{32'h0000_2000, 32'h7800_0000, 4'b1000, 20});
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort beat1 valid", 32'(mem_valid), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        stall_cnt = 0;
        @(posedge clk);
        #1;
        chk("abort mem_valid", 32'(mem_valid), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort no beat", 32'(mem_valid), 32'd0);
            chk("abort no done", 32'(done), 32'd0);
            chk("abort ready", 32'(req_ready), 32'd1);
        end

        // Reject mode: misaligned sw errors, aligned stores still go through.
        @(negedge clk);
        r0_valid = 1'b1;
        r0_addr  = 32'h0000_0001;
        r0_data  = 32'h1234_5678;
        r0_store = 2'b00;
        chk("rej ready", 32'(r0_ready), 32'd1);
        @(posedge clk);
        #1 r0_valid = 1'b0;
        @(negedge clk);
        chk("rej err pulse", 32'(err0), 32'd1);
        chk("rej no done", 32'(done0), 32'd0);
        chk("rej no beat", 32'(m0_valid), 32'd0);
        @(negedge clk);
        chk("rej err low", 32'(err0), 32'd0);
        chk("rej done low", 32'(done0), 32'd0);
        chk("rej no beat 2", 32'(m0_valid), 32'd0);
        chk("rej idle ready", 32'(r0_ready), 32'd1);

        r0_valid = 1'b1;
        r0_addr  = 32'h0000_0023;
        r0_data  = 32'h0000_00EE;
        r0_store = 2'b01;
        @(posedge clk);
        #1 r0_valid = 1'b0;
        @(negedge clk);
        chk("rej sb valid", 32'(m0_valid), 32'd1);
        chk("rej sb addr", m0_addr, 32'h0000_0020);
        chk("rej sb wdata", m0_wdata, 32'hEE00_0000);
        chk("rej sb wstrb", 32'(m0_wstrb), 32'b1000);
        chk("rej sb err", 32'(err0), 32'd0);
        @(negedge clk);
        chk("rej sb done", 32'(done0), 32'd1);
        chk("rej sb err2", 32'(err0), 32'd0);
        chk("rej sb idle", 32'(m0_valid), 32'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
